uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver. Consumes the 16x-oversample `baudtick` from the baud generator and a serial `rxd` line.
- Returns each received byte on a valid/ready output port.
- Reports framing and overrun errors.
- Sits beside the baud generator and the transmit path inside the AHB UART. The bus-side register/FIFO logic drains `rx_data`.

Parameters:
- DATA_BITS, 8, number of data bits per frame, sent LSB first.
- OVERSAMPLE, 16, number of baudticks per bit period. Must be even and >= 4.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous, active-low reset.
- baudtick  input  1  one-clk-wide pulse at OVERSAMPLE x the baud rate.
- rxd  input  1  asynchronous serial input; idles high.
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1.
- rx_valid  output  1  a byte is available.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- framing_err  output  1  one-clk pulse: stop bit was sampled low.
- overrun_err  output  1  one-clk pulse: a byte was completed while the previous byte was still unaccepted.

Behaviour:
- Reset is synchronous and active-low. On any posedge clk with resetn=0, regardless of state:
  - FSM goes to IDLE.
  - Synchronizer flops are set to 1.
  - tick_cnt=0, bit_cnt=0, shift register=0.
  - rx_data=0, rx_valid=0, framing_err=0, overrun_err=0.
- Reset mid-frame discards the partial byte.
- rxd passes through a 2-flop synchronizer before use. The FSM sees `rxs`, which lags rxd by 2 clk.
- All FSM/counter updates happen only on cycles with baudtick=1. The exceptions are output handshake and error pulses, which are evaluated every clk.
- IDLE:
  - baudtick && rxs==0 -> START, tick_cnt=0.
- START (mid-bit check of the start bit):
  - On each tick, tick_cnt++.
  - When tick_cnt==OVERSAMPLE/2-1 and rxs==0 -> DATA, tick_cnt=0, bit_cnt=0.
  - When tick_cnt==OVERSAMPLE/2-1 and rxs==1 -> false start, back to IDLE. No output, no error.
- DATA:
  - On each tick, tick_cnt++.
  - When tick_cnt==OVERSAMPLE-1: shift rxs in at the MSB (LSB-first reception), tick_cnt=0, bit_cnt++.
  - After bit DATA_BITS-1 is sampled -> STOP.
- STOP:
  - When tick_cnt==OVERSAMPLE-1, sample rxs.
  - rxs==1 -> deliver the byte, then IDLE.
  - rxs==0 -> framing_err pulse on the next clk, byte discarded, -> BREAK.
- BREAK:
  - Stay until baudtick && rxs==1, then -> IDLE.
  - A held-low line produces exactly one framing_err per break.
- Deliver (registered): rx_data and rx_valid update on the clk edge after the stop-sample tick cycle.
  - rx_valid=0, or rx_valid=1 with rx_ready=1 in that cycle: load rx_data, rx_valid=1.
  - rx_valid=1 with rx_ready=0: keep the old byte, drop the new byte, pulse overrun_err for 1 clk.
- Handshake:
  - rx_valid && rx_ready with no delivery -> rx_valid=0 on the next edge. rx_data holds its value.
  - rx_valid, once set, never drops without rx_ready or reset.
- Counter widths: tick_cnt is $clog2(OVERSAMPLE) bits. bit_cnt is $clog2(DATA_BITS+1) bits. Neither ever wraps beyond its compare value.
- Latency: the falling start edge to rx_valid is 2 clk synchronizer + ~(DATA_BITS+1.5) bit periods + 1 clk.

Decomposition:
- Shared package `uart_pkg`:
  - rx FSM state enum {IDLE, START, DATA, STOP, BREAK}.
  - constants DATA_BITS_DEF=8, OVERSAMPLE_DEF=16.
  - localparam MID_TICK = OVERSAMPLE/2-1.
- Sub-module `uart_sync2`: 2-flop synchronizer with a reset value of 1. It is reusable for the CTS input later.

Test Plan:
- Setup: baudtick every 14 clk (count=13), so one bit = 224 clk. rx_ready=1 unless stated.
- Byte 0xA5 with valid start, 8 data bits and stop=1 -> one rx_valid pulse, rx_data=0xA5, no errors.
- rxd low for 3 ticks then high (glitch) -> no rx_valid, no framing_err. A following good 0x3C frame is received correctly.
- 0x3C frame with stop bit driven 0, then line held low for 5 bit periods, then high -> exactly one framing_err pulse, no rx_valid. The next 0x81 frame is received.
- rx_ready=0; send 0x11 then 0x22 -> rx_valid=1 with rx_data=0x11, one overrun_err pulse at the end of 0x22. Then rx_ready=1 for 1 clk -> rx_valid=0, rx_data remains 0x11.
- Back-to-back 0x00 then 0xFF, stop bit only, rx_ready=1 -> two accepted bytes 0x00 and 0xFF, no errors.
- resetn=0 for 1 clk during data bit 4 of 0xF0 -> all outputs 0 on the next edge. The remainder of the frame is ignored or treated as a false start/framing error. The next clean 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int MID_TICK       = OVERSAMPLE_DEF / 2 - 1;

  // Tick index at the middle of the start bit for a given oversample ratio.
  function automatic int mid_tick(input int oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a programmable reset level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x-oversampled start/data/stop sampling, valid/ready byte output,
// framing and overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 baudtick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID_T    = TW'(mid_tick(OVERSAMPLE));
  localparam logic [TW-1:0] LAST_T   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rxs;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rxd),
    .q      (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 deliver;

  // Output handshake: a byte transfers on any edge where rx_valid && rx_ready.
  // rx_data is stable while rx_valid is high; rx_valid only drops after a transfer.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    framing_err_d = 1'b0;
    overrun_err_d = 1'b0;
    deliver       = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (baudtick) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          if (tick_cnt_q == MID_T) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rxs ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == LAST_T) begin
            shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) state_d = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt_q == LAST_T) begin
            tick_cnt_d = '0;
            if (rxs) begin
              deliver = 1'b1;
              state_d = IDLE;
            end else begin
              framing_err_d = 1'b1;
              state_d       = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        BREAK: begin
          // Wait for the line to return high so a long break reports only once.
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit, received bytes checked against a frame-level model.
module tb_uart_rx;

  localparam int TICK_CLK = 14;
  localparam int BIT_CLK  = TICK_CLK * 16;

  logic       clk;
  logic       resetn;
  logic       baudtick;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_err;
  logic       overrun_err;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .baudtick    (baudtick),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int cnt;
    cnt      = 0;
    baudtick = 1'b0;
    forever begin
      @(negedge clk);
      cnt      = (cnt == TICK_CLK - 1) ? 0 : cnt + 1;
      baudtick = (cnt == TICK_CLK - 1);
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_ovr = 0, exp_acc = 0;
  int ferr_seen = 0, ovr_seen = 0, acc_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: a good frame lands in the holding slot unless that slot
  // is still occupied and the consumer is stalled; a bad stop bit is one framing error.
  task automatic expect_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) exp_ferr++;
    else if (exp_q.size() > 0 && !rx_ready) exp_ovr++;
    else begin
      exp_q.push_back(b);
      exp_acc++;
    end
  endtask

  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      #2;
      if (framing_err) ferr_seen++;
      if (overrun_err) ovr_seen++;
      if (rx_valid && rx_ready) begin
        acc_seen++;
        check("rx_byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(exp_b));
        end
      end
    end
  end

  task automatic end_checks(input string tag);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_accepts"}, 32'(acc_seen), 32'(exp_acc));
    check({tag, "_framing"}, 32'(ferr_seen), 32'(exp_ferr));
    check({tag, "_overrun"}, 32'(ovr_seen), 32'(exp_ovr));
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int rst_bit);
    rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == rst_bit) begin
        repeat (BIT_CLK / 2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #2;
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_framing_err", 32'(framing_err), 32'd0);
        check("rst_overrun_err", 32'(overrun_err), 32'd0);
        repeat (BIT_CLK / 2 - 1) @(negedge clk);
      end else begin
        repeat (BIT_CLK) @(negedge clk);
      end
    end
    rxd = stop_v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic good_frame(input logic [7:0] b);
    expect_frame(b, 1'b1);
    send_frame(b, 1'b1, -1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rb;
    int gap;
    resetn   = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    #2;
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_framing_err", 32'(framing_err), 32'd0);
    check("reset_overrun_err", 32'(overrun_err), 32'd0);
    @(negedge clk);
    idle(BIT_CLK);

    // Basic good frame
    good_frame(8'hA5);
    idle(BIT_CLK);
    end_checks("a5");

    // Start-bit glitch is ignored, then a clean frame
    rxd = 1'b0;
    repeat (3 * TICK_CLK) @(negedge clk);
    idle(2 * BIT_CLK);
    end_checks("glitch");
    good_frame(8'h3C);
    idle(BIT_CLK);
    end_checks("after_glitch");

    // Bad stop bit followed by a long break: one framing error only
    expect_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, -1);
    rxd = 1'b0;
    repeat (5 * BIT_CLK) @(negedge clk);
    idle(BIT_CLK);
    end_checks("break");
    good_frame(8'h81);
    idle(BIT_CLK);
    end_checks("after_break");

    // Stalled consumer: second byte dropped with an overrun pulse
    rx_ready = 1'b0;
    good_frame(8'h11);
    idle(BIT_CLK);
    #2;
    check("stall_valid_first", 32'(rx_valid), 32'd1);
    check("stall_data_first", 32'(rx_data), 32'h11);
    @(negedge clk);
    good_frame(8'h22);
    idle(BIT_CLK);
    #2;
    check("stall_valid_held", 32'(rx_valid), 32'd1);
    check("stall_data_held", 32'(rx_data), 32'h11);
    check("stall_overrun", 32'(ovr_seen), 32'(exp_ovr));
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #2;
    check("drain_valid_low", 32'(rx_valid), 32'd0);
    check("drain_data_hold", 32'(rx_data), 32'h11);
    @(negedge clk);
    rx_ready = 1'b1;
    idle(BIT_CLK);
    end_checks("overrun");

    // Back-to-back frames with a single stop bit
    good_frame(8'h00);
    good_frame(8'hFF);
    idle(BIT_CLK);
    end_checks("b2b");

    // Reset during data bit 4; the partial byte is discarded
    send_frame(8'hF0, 1'b1, 4);
    idle(BIT_CLK);
    end_checks("midreset");
    good_frame(8'h5A);
    idle(BIT_CLK);
    end_checks("after_reset");

    // Random bytes with random idle gaps (random baudtick phase)
    for (int k = 0; k < 6; k++) begin
      rb  = 8'($urandom_range(0, 255));
      gap = $urandom_range(1, 400);
      idle(gap);
      good_frame(rb);
    end
    idle(BIT_CLK);
    end_checks("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
